// File: rtl/smem_retime_pipe_pkg.sv
// Shared pipeline header for the SMEM retiming stages and the queue wrappers.
// Holds the status encoding, the status field width and the legal stage-count bound.
package smem_retime_pipe_pkg;

    localparam int ST_STAT_W = 6;
    localparam logic [ST_STAT_W-1:0] ST_BUBBLE = 6'd0;
    localparam int MAX_DEPTH = 8;
    localparam int OCC_W = 4;

endpackage

// File: rtl/smem_retime_stage.sv
// One status/payload register of the retiming pipeline.
// Flush clears only the status; the payload of an emptied slot is left as it was.
module smem_retime_stage
    import smem_retime_pipe_pkg::*;
#(
    parameter int DATA_W = 1024,
    parameter int STAT_W = ST_STAT_W,
    parameter logic [STAT_W-1:0] BUBBLE = ST_BUBBLE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic [STAT_W-1:0] in_status,
    input  logic [DATA_W-1:0] in_data,
    output logic [STAT_W-1:0] status,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            status <= BUBBLE;
            data   <= '0;
        end else if (flush) begin
            status <= BUBBLE;
        end else if (load) begin
            status <= in_status;
            data   <= in_data;
        end
    end

endmodule

// File: rtl/smem_retime_pipe.sv
// Stall-gated input retiming pipeline for the SMEM datapaths.
// With COLLAPSE set, empty slots keep filling from upstream while the output is held.
module smem_retime_pipe
    import smem_retime_pipe_pkg::*;
#(
    parameter int DATA_W   = 1024,
    parameter int STAT_W   = ST_STAT_W,
    parameter int DEPTH    = 1,
    parameter int COLLAPSE = 0,
    parameter logic [STAT_W-1:0] BUBBLE = ST_BUBBLE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [STAT_W-1:0] in_status,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [STAT_W-1:0] out_status,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [OCC_W-1:0]  occupancy
);

    logic [STAT_W-1:0] stat [DEPTH];
    logic [DATA_W-1:0] data [DEPTH];
    logic [DEPTH-1:0]  acc;
    logic [DEPTH-1:0]  next_valid;
    logic [OCC_W-1:0]  occ_next;

    // A stage accepts when the stage after it accepts, or (collapsing) when it is empty.
    always_comb begin
        logic chain;
        acc   = '0;
        chain = !stall;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain  = chain | ((COLLAPSE != 0) && (stat[i] == BUBBLE));
            acc[i] = chain;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [STAT_W-1:0] src_status;
        logic [DATA_W-1:0] src_data;
        logic [STAT_W-1:0] nxt_status;

        if (i == 0) begin : g_head
            assign src_status = in_status;
            assign src_data   = in_data;
        end else begin : g_body
            assign src_status = stat[i-1];
            assign src_data   = data[i-1];
        end

        assign nxt_status    = flush ? BUBBLE : (acc[i] ? src_status : stat[i]);
        assign next_valid[i] = (nxt_status != BUBBLE);

        smem_retime_stage #(
            .DATA_W (DATA_W),
            .STAT_W (STAT_W),
            .BUBBLE (BUBBLE)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .load      (acc[i]),
            .in_status (src_status),
            .in_data   (src_data),
            .status    (stat[i]),
            .data      (data[i])
        );
    end

    always_comb begin
        occ_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_next = occ_next + OCC_W'(next_valid[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

    assign in_ready   = acc[0];
    assign out_status = stat[DEPTH-1];
    assign out_data   = data[DEPTH-1];
    assign out_valid  = (stat[DEPTH-1] != BUBBLE);

endmodule
